banco_registros_param: RTL and testbench

- Parametrised general-purpose register file for the MIPS datapath. Replaces the fixed 32x32 file.
- Two registered read ports (RS, RT), one write port, and a third registered read port for the debug unit.
- Adds same-cycle write-to-read bypass, an optional hardwired-zero register 0, and a sequenced clear engine.
- The clear engine zeroes every cell after reset or on request, with a busy flag to the control unit.

---
 rtl/banco_registros_param.sv | 172 +++++++++++++++++
 tb/tb_banco_registros_param.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/banco_registros_param.sv
// Parametrised MIPS register file: two registered read ports (RS, RT),
// one registered debug read port, one write port, optional same-cycle
// write-to-read bypass, optional hardwired-zero register 0 and a
// sequenced clear engine that sweeps every cell to zero after reset or
// on request, flagging o_Busy while it runs.
module banco_registros_param #(
    parameter int NBITS    = 32,
    parameter int CELDAS   = 32,
    parameter int REGS     = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_RegWrite,
    input  logic [REGS-1:0]   i_RS,
    input  logic [REGS-1:0]   i_RT,
    input  logic [REGS-1:0]   i_RD,
    input  logic [NBITS-1:0]  i_DatoEscritura,
    input  logic              i_Clear,
    input  logic [REGS-1:0]   i_DebugAddr,
    output logic [NBITS-1:0]  o_RS,
    output logic [NBITS-1:0]  o_RT,
    output logic [NBITS-1:0]  o_DebugDato,
    output logic              o_Busy
);

    // Internal cell index width; CELDAS <= 2^REGS so AW <= REGS.
    localparam int AW = (CELDAS > 1) ? $clog2(CELDAS) : 1;
    localparam logic [AW-1:0]  LAST_CELL = AW'(CELDAS - 1);
    localparam logic [REGS:0]  CELDAS_W  = (REGS + 1)'(CELDAS);
    localparam int NPORTS = 3;   // 0 = RS, 1 = RT, 2 = debug

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;

    logic [NBITS-1:0]  mem [0:CELDAS-1];
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [NBITS-1:0]  mem_wdata;

    logic [REGS-1:0]   raddr      [NPORTS];
    logic [NBITS-1:0]  idle_val   [NPORTS];
    logic [NBITS-1:0]  rdata_q    [NPORTS];
    logic [NBITS-1:0]  rdata_d    [NPORTS];

    logic              wr_legal;

    // An address names a real cell only when it is below CELDAS.
    function automatic logic addr_ok(input logic [REGS-1:0] a);
        return ({1'b0, a} < CELDAS_W);
    endfunction

    assign raddr[0] = i_RS;
    assign raddr[1] = i_RT;
    assign raddr[2] = i_DebugAddr;

    // A write is legal when enabled, in range and not aimed at a hardwired zero.
    assign wr_legal = i_RegWrite && addr_ok(i_RD) &&
                      !((ZERO_REG != 0) && (i_RD == '0));

    // Per-port read value while idle: range check, zero register, bypass, array.
    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_rport
            logic [NBITS-1:0] port_val;

            // Priority chain that selects what this port registers next edge.
            always_comb begin
                port_val = '0;
                if (!addr_ok(raddr[gi])) begin
                    port_val = '0;
                end else if ((ZERO_REG != 0) && (raddr[gi] == '0)) begin
                    port_val = '0;
                end else if ((BYPASS != 0) && wr_legal && (i_RD == raddr[gi])) begin
                    port_val = i_DatoEscritura;
                end else begin
                    port_val = mem[raddr[gi][AW-1:0]];
                end
            end

            assign idle_val[gi] = port_val;
        end
    endgenerate

    // State register: FSM, sweep counter, busy flag and read data flops.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            for (int i = 0; i < NPORTS; i++) begin
                rdata_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            for (int i = 0; i < NPORTS; i++) begin
                rdata_q[i] <= rdata_d[i];
            end
        end
    end

    // Next-state logic: sweep cells in CLEAR, leave after the last one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        case (state_q)
            S_CLEAR: begin
                if (cnt_q == LAST_CELL) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: begin
                if (i_Clear) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
        endcase
    end

    // Output logic: array write port and read data; reads are forced to 0 while clearing.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = i_RD[AW-1:0];
        mem_wdata = i_DatoEscritura;
        for (int i = 0; i < NPORTS; i++) begin
            rdata_d[i] = '0;
        end
        if (!i_reset) begin
            case (state_q)
                S_CLEAR: begin
                    mem_we    = 1'b1;
                    mem_waddr = cnt_q;
                    mem_wdata = '0;
                end
                default: begin
                    mem_we = wr_legal;
                    for (int i = 0; i < NPORTS; i++) begin
                        rdata_d[i] = idle_val[i];
                    end
                end
            endcase
        end
    end

    // Single write port of the storage array (no reset; the clear engine zeroes it).
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign o_RS        = rdata_q[0];
    assign o_RT        = rdata_q[1];
    assign o_DebugDato = rdata_q[2];
    assign o_Busy      = busy_q;

endmodule

// File: tb/tb_banco_registros_param.sv
// Directed bench for banco_registros_param. Three instances share stimulus:
//   A: defaults (32 cells, ZERO_REG=1, BYPASS=1)
//   B: 16 cells, ZERO_REG=0, BYPASS=0
//   C: 32 cells, ZERO_REG=0, BYPASS=1
module tb_banco_registros_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  rs, rt, rd, dbg;
    logic [31:0] wd;
    logic        clr;

    logic [31:0] a_rs, a_rt, a_dbg, b_rs, b_rt, b_dbg, c_rs, c_rt, c_dbg;
    logic        a_busy, b_busy, c_busy;

    int n_assert = 0;
    int n_fail   = 0;
    int na, nb, nc, bad;

    always #5 clk = ~clk;

    banco_registros_param dut_a (
        .i_clk(clk), .i_reset(rst), .i_RegWrite(we), .i_RS(rs), .i_RT(rt),
        .i_RD(rd), .i_DatoEscritura(wd), .i_Clear(clr), .i_DebugAddr(dbg),
        .o_RS(a_rs), .o_RT(a_rt), .o_DebugDato(a_dbg), .o_Busy(a_busy)
    );

    banco_registros_param #(.NBITS(32), .CELDAS(16), .REGS(5), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_RegWrite(we), .i_RS(rs), .i_RT(rt),
        .i_RD(rd), .i_DatoEscritura(wd), .i_Clear(clr), .i_DebugAddr(dbg),
        .o_RS(b_rs), .o_RT(b_rt), .o_DebugDato(b_dbg), .o_Busy(b_busy)
    );

    banco_registros_param #(.NBITS(32), .CELDAS(32), .REGS(5), .ZERO_REG(0), .BYPASS(1)) dut_c (
        .i_clk(clk), .i_reset(rst), .i_RegWrite(we), .i_RS(rs), .i_RT(rt),
        .i_RD(rd), .i_DatoEscritura(wd), .i_Clear(clr), .i_DebugAddr(dbg),
        .o_RS(c_rs), .o_RT(c_rt), .o_DebugDato(c_dbg), .o_Busy(c_busy)
    );

    // Inputs change right after a falling edge; outputs are sampled there too.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-12s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Counts clock periods with busy high per instance, bounded to 40 cycles.
    // A pending write is dropped after 10 cycles; A must read 0 while busy.
    task automatic count_busy(output int ca, output int cb, output int cc, output int cbad);
        ca = 0; cb = 0; cc = 0; cbad = 0;
        for (int i = 0; i < 40; i++) begin
            if (a_busy) ca++;
            if (b_busy) cb++;
            if (c_busy) cc++;
            if (a_busy && ((a_rs | a_rt | a_dbg) != 32'h0)) cbad++;
            tick();
            if (i == 9) we = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; rs = '0; rt = '0; rd = '0; dbg = '0; wd = '0; clr = 1'b0;

        // Reset state, held reset
        tick(); tick();
        chk("rst_rs", a_rs, 32'h0);
        chk("rst_rt", a_rt, 32'h0);
        chk("rst_dbg", a_dbg, 32'h0);
        chk("rst_busy_a", {31'h0, a_busy}, 32'h1);
        tick();
        chk("rst_held_b", {31'h0, b_busy}, 32'h1);

        // Release: post-reset sweep
        rst = 1'b0;
        count_busy(na, nb, nc, bad);
        chk("swp_a", na, 32);
        chk("swp_b", nb, 16);
        chk("swp_c", nc, 32);
        chk("swp_zero", bad, 0);

        // Every address reads 0 after the sweep
        for (int a = 0; a < 32; a++) begin
            rs = 5'(a); rt = 5'(a); dbg = 5'(a);
            tick();
            chk($sformatf("z_a%0d", a), a_rs | a_rt | a_dbg, 32'h0);
            chk($sformatf("z_b%0d", a), b_rs | b_rt | b_dbg, 32'h0);
            chk($sformatf("z_c%0d", a), c_rs | c_rt | c_dbg, 32'h0);
        end

        // Write r5 then read on all ports
        we = 1'b1; rd = 5'd5; wd = 32'hDEADBEEF; rs = '0; rt = '0; dbg = '0;
        tick();
        we = 1'b0; rs = 5'd5; rt = 5'd5; dbg = 5'd5;
        tick();
        chk("r5_rs", a_rs, 32'hDEADBEEF);
        chk("r5_rt", a_rt, 32'hDEADBEEF);
        chk("r5_dbg", a_dbg, 32'hDEADBEEF);
        chk("r5_b", b_rs, 32'hDEADBEEF);
        chk("r5_c", c_dbg, 32'hDEADBEEF);

        // Same-cycle write/read r7: bypass vs no bypass
        we = 1'b1; rd = 5'd7; wd = 32'h12345678; rs = 5'd7; rt = 5'd5;
        tick();
        chk("byp_a", a_rs, 32'h12345678);
        chk("byp_b_old", b_rs, 32'h0);
        chk("byp_c", c_rs, 32'h12345678);
        chk("byp_a_rt", a_rt, 32'hDEADBEEF);
        we = 1'b0;
        tick();
        chk("byp_b_new", b_rs, 32'h12345678);
        chk("r7_a", a_rs, 32'h12345678);

        // Register 0 write
        we = 1'b1; rd = 5'd0; wd = 32'hFFFFFFFF; rs = 5'd0;
        tick();
        chk("r0_a_same", a_rs, 32'h0);
        chk("r0_b_same", b_rs, 32'h0);
        chk("r0_c_same", c_rs, 32'hFFFFFFFF);
        we = 1'b0;
        tick();
        chk("r0_a_next", a_rs, 32'h0);
        chk("r0_b_next", b_rs, 32'hFFFFFFFF);
        chk("r0_c_next", c_rs, 32'hFFFFFFFF);

        // r20: out of range for the 16-cell instance
        we = 1'b1; rd = 5'd20; wd = 32'hAA; rs = 5'd20;
        tick();
        chk("r20_a_same", a_rs, 32'hAA);
        chk("r20_b_same", b_rs, 32'h0);
        chk("r20_c_same", c_rs, 32'hAA);
        we = 1'b0;
        tick();
        chk("r20_a", a_rs, 32'hAA);
        chk("r20_b", b_rs, 32'h0);
        chk("r20_c", c_rs, 32'hAA);

        // Populate r1, r4, then request a clear; write r2 during busy
        we = 1'b1; rd = 5'd1; wd = 32'd3;
        tick();
        rd = 5'd4; wd = 32'h3FFFFFFE;
        tick();
        we = 1'b0; rs = 5'd1; rt = 5'd4; dbg = 5'd0;
        tick();
        chk("pop_r1", a_rs, 32'd3);
        chk("pop_r4", a_rt, 32'h3FFFFFFE);
        rs = '0; rt = '0; dbg = '0; clr = 1'b1;
        tick();
        clr = 1'b0; we = 1'b1; rd = 5'd2; wd = 32'd9;
        count_busy(na, nb, nc, bad);
        chk("clr_a", na, 32);
        chk("clr_b", nb, 16);
        chk("clr_c", nc, 32);
        chk("clr_zero", bad, 0);
        rs = 5'd1; rt = 5'd2; dbg = 5'd4;
        tick();
        chk("clr_r1", a_rs, 32'h0);
        chk("clr_r2", a_rt, 32'h0);
        chk("clr_r4", a_dbg, 32'h0);
        chk("clr_b_r2", b_rt, 32'h0);
        chk("clr_c_r4", c_dbg, 32'h0);

        // Reset in the middle of a clear sweep
        we = 1'b1; rd = 5'd3; wd = 32'h55;
        tick();
        we = 1'b0; rs = 5'd3;
        tick();
        chk("r3_set", a_rs, 32'h55);
        rs = '0; clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        count_busy(na, nb, nc, bad);
        chk("mid_a", na, 32);
        chk("mid_b", nb, 16);
        chk("mid_c", nc, 32);
        chk("mid_zero", bad, 0);
        rs = 5'd3; rt = 5'd5; dbg = 5'd7;
        tick();
        chk("mid_r3", a_rs, 32'h0);
        chk("mid_r5", a_rt, 32'h0);
        chk("mid_r7", a_dbg, 32'h0);
        chk("mid_b_r3", b_rs, 32'h0);
        chk("mid_c_r3", c_rs, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
